dmem_lsu: RTL and testbench



---
 rtl/dmem_lsu_if.sv | 22 ++
 rtl/dmem_lsu.sv | 137 +++++++++++++
 tb/tb_dmem_lsu.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: data-port bundle between the RV32I core and dmem_lsu.
//   master (core): drives addr, wdata, size, wen, ren;
//                  receives rdata, misalign, halt, exit_code.
//   slave  (dmem): the mirror image.
interface dmem_lsu_if #(
  parameter int XLEN = 32
) ();
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [1:0]      size;
  logic            wen;
  logic            ren;
  logic [XLEN-1:0] rdata;
  logic            misalign;
  logic            halt;
  logic [XLEN-1:0] exit_code;

  modport master (output addr, wdata, size, wen, ren,
                  input  rdata, misalign, halt, exit_code);
  modport slave  (input  addr, wdata, size, wen, ren,
                  output rdata, misalign, halt, exit_code);
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressed data RAM plus load/store unit for the single-cycle
// RV32I core. Loads return combinationally in the request cycle; stores land
// on the rising edge. RAM addressing wraps modulo DEPTH*4 bytes.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - synchronous, active-low; clears RAM, counter, halt, exit_code
//   bus    - dmem_lsu_if.slave: addr/wdata/size/wen/ren in,
//            rdata/misalign/halt/exit_code out
//
// Optional feature macro DMEM_MMIO_EN: adds a 256-byte MMIO window at
// MMIO_BASE with a free-running 64-bit cycle counter (0x00 lo, 0x04 hi),
// a sticky HALT register (0x08) and EXIT readback (0x0C). Without the macro
// the window addresses are ordinary wrapped RAM and halt/exit_code are 0.
module dmem_lsu #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 32,
  parameter logic [XLEN-1:0] MMIO_BASE = 32'hFFFF_FF00
) (
  input  logic       clk,
  input  logic       reset,
  dmem_lsu_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] mem [DEPTH];

  logic [AW-1:0]   widx;
  logic [1:0]      boff;
  logic            req;
  logic            ram_bad;
  logic [NB-1:0]   be;
  logic [XLEN-1:0] wsh;
  logic [XLEN-1:0] rsh;
  logic [XLEN-1:0] ram_rd;
  logic            store_ok;

  // MMIO-side signals; tied off when the window is compiled out.
  logic            in_mmio;
  logic            mmio_bad;
  logic [XLEN-1:0] mmio_rd;
  logic            halt_q;
  logic [XLEN-1:0] exit_q;

  assign widx = bus.addr[AW+1:2];
  assign boff = bus.addr[1:0];
  assign req  = bus.wen | bus.ren;

  always_comb begin
    ram_bad = 1'b0;
    be      = '1;
    unique case (bus.size)
      2'b00: be = NB'(1) << boff;
      2'b01: begin
        ram_bad = boff[0];
        be      = NB'(3) << boff;
      end
      2'b10: ram_bad = (boff != 2'b00);
      default: ram_bad = 1'b1;
    endcase
  end

  // Lane steering: store data moves up into its byte lanes, load data moves
  // down to bit 0 and is zero-masked to the access width.
  assign wsh = bus.wdata << {boff, 3'b000};
  assign rsh = mem[widx] >> {boff, 3'b000};

  always_comb begin
    case (bus.size)
      2'b00:   ram_rd = XLEN'(rsh[7:0]);
      2'b01:   ram_rd = XLEN'(rsh[15:0]);
      default: ram_rd = rsh;
    endcase
  end

  assign bus.misalign  = req & (in_mmio ? mmio_bad : ram_bad);
  assign bus.rdata     = (bus.ren & ~bus.misalign) ? (in_mmio ? mmio_rd : ram_rd) : '0;
  assign bus.halt      = halt_q;
  assign bus.exit_code = exit_q;
  assign store_ok      = bus.wen & ~bus.misalign & ~halt_q;

  // Reset clears every word and wins over a concurrent store.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (store_ok && !in_mmio) begin
      for (int b = 0; b < NB; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wsh[8*b +: 8];
    end
  end

`ifdef DMEM_MMIO_EN
  logic [63:0] cycle;
  logic        halt_wr;

  assign in_mmio  = (bus.addr[XLEN-1:8] == MMIO_BASE[XLEN-1:8]);
  assign mmio_bad = (bus.size != 2'b10) || (boff != 2'b00);
  assign halt_wr  = store_ok & in_mmio & (bus.addr[7:0] == 8'h08);

  always_comb begin
    case (bus.addr[7:0])
      8'h00:   mmio_rd = XLEN'(cycle[31:0]);
      8'h04:   mmio_rd = XLEN'(cycle[63:32]);
      8'h08:   mmio_rd = XLEN'(halt_q);
      8'h0C:   mmio_rd = exit_q;
      default: mmio_rd = '0;
    endcase
  end

  // The counter also holds on the HALT-write edge, so the value read in the
  // HALT cycle is the value it stays frozen at.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle  <= '0;
      halt_q <= 1'b0;
      exit_q <= '0;
    end else begin
      if (halt_wr) begin
        halt_q <= 1'b1;
        exit_q <= bus.wdata;
      end
      if (!halt_q && !halt_wr) cycle <= cycle + 64'd1;
    end
  end
`else
  logic unused_cfg;

  assign in_mmio    = 1'b0;
  assign mmio_bad   = 1'b0;
  assign mmio_rd    = '0;
  assign halt_q     = 1'b0;
  assign exit_q     = '0;
  // Upper address bits and the window base have no meaning in this build.
  assign unused_cfg = ^{MMIO_BASE, bus.addr};
`endif
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: randomized scoreboard bench for dmem_lsu. The stimulus side
// drives one request per cycle, computes the expected outputs from a byte-array
// reference model and queues them; a negedge monitor pops and compares.
module tb_dmem_lsu;
  localparam int          XLEN      = 32;
  localparam int          DEPTH     = 32;
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_FF00;
  localparam int          NBYTES    = DEPTH * 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  dmem_lsu_if #(.XLEN(XLEN)) bus ();

  dmem_lsu #(.XLEN(XLEN), .DEPTH(DEPTH), .MMIO_BASE(MMIO_BASE)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
    logic        halt;
    logic [31:0] exit_code;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: plain byte array plus halt/exit state.
  logic [7:0]  mb [NBYTES];
  logic        m_halt;
  logic [31:0] m_exit;
`ifdef DMEM_MMIO_EN
  logic [63:0] m_cyc;
`endif

  function automatic logic is_mmio(input logic [31:0] a);
`ifdef DMEM_MMIO_EN
    return a[31:8] == MMIO_BASE[31:8];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic model_mis(input logic w, input logic r,
                                     input logic [31:0] a, input logic [1:0] sz);
    if (!(w || r)) return 1'b0;
    if (is_mmio(a)) return !(sz == 2'd2 && a % 4 == 0);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return (a % 2) != 0;
      2'd2:    return (a % 4) != 0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] v;
    int          base;
    int          n;
    v = 32'd0;
    if (is_mmio(a)) begin
`ifdef DMEM_MMIO_EN
      case (a % 256)
        0:       v = m_cyc[31:0];
        4:       v = m_cyc[63:32];
        8:       v = {31'd0, m_halt};
        12:      v = m_exit;
        default: v = 32'd0;
      endcase
`endif
      return v;
    end
    base = int'(a % NBYTES);
    n    = 1 << sz;
    for (int i = 0; i < n; i++) v = v | (32'(mb[base+i]) << (8*i));
    return v;
  endfunction

  // Effect of the coming rising edge on the model.
  task automatic model_edge(input logic w, input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] d, input logic mis);
    logic halt_now;
    int   base;
    halt_now = 1'b0;
    if (w && !mis && !m_halt) begin
      if (is_mmio(a)) begin
        if (a % 256 == 8) begin
          halt_now = 1'b1;
          m_exit   = d;
        end
      end else begin
        base = int'(a % NBYTES);
        for (int i = 0; i < (1 << sz); i++) mb[base+i] = 8'(d >> (8*i));
      end
    end
`ifdef DMEM_MMIO_EN
    if (!m_halt && !halt_now) m_cyc = m_cyc + 64'd1;
`endif
    if (halt_now) m_halt = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NBYTES; i++) mb[i] = 8'd0;
    m_halt = 1'b0;
    m_exit = 32'd0;
`ifdef DMEM_MMIO_EN
    m_cyc  = 64'd0;
`endif
  endtask

  // One request cycle with expectation queued for the monitor.
  task automatic op(input logic w, input logic r, input logic [31:0] a,
                    input logic [1:0] sz, input logic [31:0] d);
    exp_t e;
    logic mis;
    @(posedge clk); #1;
    reset     = 1'b1;
    bus.wen   = w;
    bus.ren   = r;
    bus.addr  = a;
    bus.size  = sz;
    bus.wdata = d;
    mis         = model_mis(w, r, a, sz);
    e.mis       = mis;
    e.rdata     = (r && !mis) ? model_load(a, sz) : 32'd0;
    e.halt      = m_halt;
    e.exit_code = m_exit;
    sb.push_back(e);
    model_edge(w, a, sz, d, mis);
  endtask

  // Reset cycle, optionally with a word store that must be discarded.
  task automatic do_reset(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    reset     = 1'b0;
    bus.wen   = w;
    bus.ren   = 1'b0;
    bus.addr  = a;
    bus.size  = 2'd2;
    bus.wdata = d;
    model_reset();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rdata",     bus.rdata,            e.rdata);
      chk("misalign",  32'(bus.misalign),    32'(e.mis));
      chk("halt",      32'(bus.halt),        32'(e.halt));
      chk("exit_code", bus.exit_code,        e.exit_code);
    end
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    bus.wen = 1'b0; bus.ren = 1'b0; bus.addr = '0; bus.size = '0; bus.wdata = '0;
    model_reset();

    do_reset(1'b0, 32'h0, 32'h0);
    op(0, 1, 32'h10, 2'd2, 0);              // reads 0 after reset
    op(0, 0, 32'h0,  2'd0, 0);

    // Byte steering.
    op(1, 0, 32'h08, 2'd2, 32'hDEADBEEF);
    op(1, 0, 32'h09, 2'd0, 32'h00000055);
    op(0, 1, 32'h08, 2'd2, 0);              // 0xDEAD55EF
    op(0, 1, 32'h0B, 2'd0, 0);              // 0xDE
    op(0, 1, 32'h0A, 2'd1, 0);              // 0xDEAD

    // Misaligned / illegal requests leave RAM alone and return 0.
    op(1, 0, 32'h03, 2'd1, 32'hFFFF);
    op(0, 1, 32'h06, 2'd2, 0);
    op(1, 1, 32'h08, 2'd3, 32'hFFFFFFFF);
    op(0, 1, 32'h08, 2'd2, 0);
    op(0, 1, 32'h00, 2'd2, 0);

    // Address wrap.
    op(1, 0, 32'h08, 2'd2, 32'h00001234);
    op(0, 1, 32'h88, 2'd2, 0);

    // Read-during-write returns pre-write contents.
    op(1, 0, 32'h20, 2'd2, 32'hAAAA5555);
    op(1, 1, 32'h20, 2'd2, 32'h12345678);
    op(0, 1, 32'h20, 2'd2, 0);
    op(1, 1, 32'h22, 2'd1, 32'h0000BEEF);
    op(0, 1, 32'h20, 2'd2, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      a  = $urandom;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, sz, $urandom);
    end

    // Store in the reset cycle is dropped.
    op(1, 0, 32'h40, 2'd2, 32'h99);
    op(0, 1, 32'h40, 2'd2, 0);
    do_reset(1'b1, 32'h40, 32'h77);
    op(0, 1, 32'h40, 2'd2, 0);

`ifdef DMEM_MMIO_EN
    do_reset(1'b0, 32'h0, 32'h0);
    repeat (10) op(0, 0, 32'h0, 2'd0, 0);
    op(0, 1, 32'hFFFF_FF00, 2'd2, 0);       // CYC_LO = 10
    if (model_load(32'hFFFF_FF00, 2'd2) != 32'd11)
      chk("cyc_model", model_load(32'hFFFF_FF00, 2'd2), 32'd11);
    op(0, 1, 32'hFFFF_FF04, 2'd2, 0);
    op(1, 0, 32'h10, 2'd2, 32'h0000CAFE);
    op(0, 1, 32'hFFFF_FF01, 2'd0, 0);       // sub-word MMIO is misaligned
    op(1, 0, 32'hFFFF_FF08, 2'd2, 32'h2A);  // HALT
    op(0, 1, 32'hFFFF_FF00, 2'd2, 0);
    op(0, 1, 32'hFFFF_FF00, 2'd2, 0);
    op(1, 0, 32'h10, 2'd2, 32'hFFFFFFFF);   // ignored after halt
    op(0, 1, 32'h10, 2'd2, 0);
    op(1, 0, 32'hFFFF_FF08, 2'd2, 32'h55);  // second HALT ignored
    op(0, 1, 32'hFFFF_FF08, 2'd2, 0);
    op(0, 1, 32'hFFFF_FF0C, 2'd2, 0);
    op(0, 1, 32'hFFFF_FF10, 2'd2, 0);
    op(0, 1, 32'hFFFF_FF00, 2'd2, 0);
    do_reset(1'b0, 32'h0, 32'h0);
    op(0, 1, 32'hFFFF_FF08, 2'd2, 0);
`else
    op(1, 0, 32'hFFFF_FF08, 2'd2, 32'h2A);  // plain wrapped RAM word
    op(0, 1, 32'h08, 2'd2, 0);
`endif

    op(0, 0, 32'h0, 2'd0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
